// File: rtl/pipe_block_sequencer.sv
// Block sequencer between the pipe-in FIFO read side, a compute core and the
// pipe-out FIFO write side. A block of BLOCK_WORDS words starts only when the
// whole block is already buffered on input and fits in the output FIFO, so
// host-side block transfers never stall mid-block.
module pipe_block_sequencer #(
  parameter int DATA_W      = 256,
  parameter int BLOCK_WORDS = 16,
  parameter int OUT_DEPTH   = 128,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  in_rd_count,
  input  logic              in_empty,
  output logic              in_rd_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              core_in_valid,
  output logic [DATA_W-1:0] core_in_data,
  input  logic              core_out_valid,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              out_full,
  input  logic [CNT_W-1:0]  out_wr_count,
  output logic              out_wr_en,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              block_done,
  output logic [15:0]       block_count,
  output logic [1:0]        err
);

  // Word counters must hold the value BLOCK_WORDS itself.
  localparam int BC_W = $clog2(BLOCK_WORDS + 1);
  localparam logic [BC_W-1:0]  BW     = BC_W'(BLOCK_WORDS);
  localparam logic [BC_W-1:0]  BW_M1  = BC_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W:0]   BW_X   = (CNT_W+1)'(BLOCK_WORDS);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W+1)'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t          state;
  logic [BC_W-1:0] rd_cnt;
  logic [BC_W-1:0] wr_cnt;
  logic [CNT_W:0]  out_free;
  logic            start_ok;
  logic            res_acc;

  // Free space is computed one bit wider so OUT_DEPTH itself is representable.
  assign out_free = DEPTH_X - {1'b0, out_wr_count};

  // A block may begin only when it can run end to end without stalling.
  assign start_ok = enable
                  && ({1'b0, in_rd_count} >= BW_X)
                  && (out_free >= BW_X);

  // Reads are issued straight from state so the FIFO sees them the same cycle.
  assign in_rd_en = (state == READ) && (rd_cnt < BW) && !in_empty;

  // A core result belongs to the current block only while one is in flight
  // and the block has not yet collected all of its results.
  assign res_acc = core_out_valid
                 && ((state == READ) || (state == DRAIN))
                 && (wr_cnt < BW);

  // Block sequencing FSM with registered busy/done/count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      busy        <= 1'b0;
      block_done  <= 1'b0;
      block_count <= '0;
    end else begin
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= READ;
            rd_cnt <= '0;
            busy   <= 1'b1;
          end
        end
        READ: begin
          if (in_rd_en) begin
            rd_cnt <= rd_cnt + BC_W'(1);
            if (rd_cnt == BW_M1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wr_cnt == BW) begin
            state       <= DONE;
            block_done  <= 1'b1;
            block_count <= block_count + 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Result counting; res_acc is never true in IDLE, so the clear at
      // block start cannot collide with an increment.
      if (state == IDLE && start_ok) wr_cnt <= '0;
      else if (res_acc)              wr_cnt <= wr_cnt + BC_W'(1);
    end
  end

  // Input path: FIFO read data re-timed by one stage toward the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in_valid <= 1'b0;
      core_in_data  <= '0;
    end else begin
      core_in_valid <= in_valid;
      core_in_data  <= in_data;
    end
  end

  // Output path: accepted results go to the output FIFO unless it is full;
  // a full FIFO drops the word but the result still counts toward the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_en <= 1'b0;
      out_data  <= '0;
    end else begin
      out_wr_en <= res_acc && !out_full;
      if (res_acc) out_data <= core_out_data;
    end
  end

  // Sticky error flags, cleared only by reset; they never affect sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else begin
      if (res_acc && out_full)        err[0] <= 1'b1;
      if (core_out_valid && !res_acc) err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_block_sequencer.sv
// Directed bench for pipe_block_sequencer: behavioural input FIFO, a 3-cycle
// delay core and an output-side monitor around the DUT.
module tb_pipe_block_sequencer;
  localparam int DW = 256;
  localparam int BW = 16;
  localparam int OD = 128;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [CW-1:0] in_rd_count;
  logic          in_empty;
  logic          in_rd_en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          core_in_valid;
  logic [DW-1:0] core_in_data;
  logic          core_out_valid;
  logic [DW-1:0] core_out_data;
  logic          out_full;
  logic [CW-1:0] out_wr_count;
  logic          out_wr_en;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          block_done;
  logic [15:0]   block_count;
  logic [1:0]    err;

  pipe_block_sequencer #(.DATA_W(DW), .BLOCK_WORDS(BW), .OUT_DEPTH(OD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_rd_count(in_rd_count), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .in_valid(in_valid), .in_data(in_data),
    .core_in_valid(core_in_valid), .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .out_full(out_full), .out_wr_count(out_wr_count),
    .out_wr_en(out_wr_en), .out_data(out_data),
    .busy(busy), .block_done(block_done), .block_count(block_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return {8{32'h5A00_0000 | 32'(i)}};
  endfunction

  // Input FIFO level = words ever loaded minus words ever read.
  int avail = 0;
  int rd_total = 0;
  int lvl;
  always_comb begin
    lvl = avail - rd_total;
    in_rd_count = (lvl > 255) ? 8'hFF : CW'(lvl);
    in_empty = (lvl <= 0);
  end

  // FIFO read latency and 3-cycle core, cleared with the DUT reset.
  logic [2:0]    cpipe;
  logic [DW-1:0] cdat0, cdat1, cdat2;
  logic          inj;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      in_data  <= '0;
      cpipe    <= '0;
    end else begin
      in_valid <= in_rd_en;
      in_data  <= word(rd_total);
      cpipe    <= {cpipe[1:0], core_in_valid};
      cdat0    <= core_in_data;
      cdat1    <= cdat0;
      cdat2    <= cdat1;
    end
  end
  assign core_out_valid = cpipe[2] | inj;
  assign core_out_data  = cdat2;

  // Monitor: monotonic event totals, written data, done-to-read gaps.
  int cyc = 0, wr_total = 0, done_total = 0, cov_total = 0, done_cyc = 0;
  int gap_arr [0:63];
  logic rd_en_q = 1'b0;
  logic [DW-1:0] out_mem [0:255];
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_en_q <= in_rd_en;
    if (in_rd_en) rd_total <= rd_total + 1;
    if (core_out_valid) cov_total <= cov_total + 1;
    if (out_wr_en) begin
      out_mem[wr_total[7:0]] <= out_data;
      wr_total <= wr_total + 1;
    end
    if (block_done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
    if (in_rd_en && !rd_en_q) gap_arr[done_total[5:0]] <= cyc - done_cyc;
  end

  task automatic wait_done(input int tgt);
    for (int k = 0; k < 400 && done_total < tgt; k++) @(negedge clk);
    chk("done_wait", 256'(done_total), 256'(tgt));
  endtask

  int wr0, cb, r0, r1;

  initial begin
    rst_n = 1'b0; enable = 1'b0; out_full = 1'b0; out_wr_count = '0; inj = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy, block_done, in_rd_en, core_in_valid, out_wr_en, block_count, err}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic block
    avail = 16; enable = 1'b1;
    wait_done(1);
    repeat (10) @(negedge clk);
    chk("b1_reads", 256'(rd_total), 256'(16));
    chk("b1_writes", 256'(wr_total), 256'(16));
    chk("b1_count", 256'(block_count), 256'(1));
    chk("b1_err", 256'(err), 256'(0));
    chk("b1_busy", 256'(busy), 256'(0));
    for (int k = 0; k < 16; k++) chk($sformatf("b1_data%0d", k), out_mem[k], word(k));

    // Level 15 must not start; 16 starts next cycle
    avail = avail + 15;
    repeat (20) @(negedge clk);
    chk("lvl15_noread", 256'(rd_total), 256'(16));
    avail = avail + 1;
    @(negedge clk);
    chk("lvl16_start", 256'(in_rd_en), 256'(1));
    wait_done(2);
    repeat (10) @(negedge clk);
    chk("b2_count", 256'(block_count), 256'(2));

    // Output free space 15 blocks start; 16 allows it; enable drop mid-block
    out_wr_count = 8'd113; avail = avail + 32;
    repeat (20) @(negedge clk);
    chk("free15_noread", 256'(rd_total), 256'(32));
    out_wr_count = 8'd112;
    @(negedge clk);
    chk("free16_start", 256'(in_rd_en), 256'(1));
    enable = 1'b0;
    wait_done(3);
    repeat (30) @(negedge clk);
    chk("en_drop_reads", 256'(rd_total), 256'(48));
    chk("en_drop_idle", 256'(busy), 256'(0));

    // Back-to-back blocks
    out_wr_count = '0; avail = avail + 32; enable = 1'b1;
    wait_done(6);
    repeat (10) @(negedge clk);
    chk("b2b_reads", 256'(rd_total), 256'(96));
    chk("b2b_count", 256'(block_count), 256'(6));
    chk("b2b_gap1", 256'(gap_arr[4]), 256'(2));
    chk("b2b_gap2", 256'(gap_arr[5]), 256'(2));
    chk("b2b_err", 256'(err), 256'(0));

    // Output full during result 5
    avail = avail + 16; cb = cov_total; wr0 = wr_total;
    for (int k = 0; k < 300 && done_total < 7; k++) begin
      @(negedge clk);
      out_full = (cov_total == cb + 5) && core_out_valid;
    end
    out_full = 1'b0;
    chk("full_done", 256'(done_total), 256'(7));
    repeat (5) @(negedge clk);
    chk("full_err", 256'(err), 256'(2'b01));
    chk("full_writes", 256'(wr_total - wr0), 256'(15));
    chk("full_count", 256'(block_count), 256'(7));
    // Stray core result while idle
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    @(negedge clk);
    chk("stray_err", 256'(err), 256'(2'b11));

    // Async reset mid-read, then fresh block with enable dropped
    avail = avail + 48; r0 = rd_total;
    for (int k = 0; k < 100 && (rd_total - r0) < 7; k++) @(negedge clk);
    chk("rst_at7", 256'(rd_total - r0), 256'(7));
    rst_n = 1'b0;
    #1;
    chk("async_rst", {busy, block_done, in_rd_en, core_in_valid, out_wr_en, block_count, err}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; r1 = rd_total;
    for (int k = 0; k < 100 && (rd_total - r1) < 3; k++) @(negedge clk);
    enable = 1'b0;
    wait_done(8);
    repeat (30) @(negedge clk);
    chk("post_rst_reads", 256'(rd_total - r1), 256'(16));
    chk("post_rst_count", 256'(block_count), 256'(1));
    chk("post_rst_err", 256'(err), 256'(0));
    chk("post_rst_idle", 256'(busy), 256'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_block_sequencer.md
Name: pipe_block_sequencer

Overview:
- Sits in the user `clk` domain between the read side of the pipe-in FIFO, a compute core, and the write side of the pipe-out FIFO.
- Moves data in blocks of BLOCK_WORDS wide words. A block starts only when the input FIFO holds a whole block and the output FIFO has room for a whole block, so host block transfers never stall mid-block.
- Provides block accounting and sticky error flags for host readback.

Parameters:
DATA_W, 256, width of in/core/out data words
BLOCK_WORDS, 16, words per block (one 128 x 32-bit host block)
OUT_DEPTH, 128, output FIFO depth in DATA_W words
CNT_W, 8, width of FIFO data-count inputs

Ports:
clk  input  1  user clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permit new block starts
in_rd_count  input  CNT_W  input FIFO read-side data count
in_empty  input  1  input FIFO empty
in_rd_en  output  1  input FIFO read enable (combinational)
in_valid  input  1  input FIFO read data valid (1-cycle read latency)
in_data  input  DATA_W  input FIFO read data
core_in_valid  output  1  word to core valid
core_in_data  output  DATA_W  word to core
core_out_valid  input  1  core result valid
core_out_data  input  DATA_W  core result
out_full  input  1  output FIFO full
out_wr_count  input  CNT_W  output FIFO write-side data count
out_wr_en  output  1  output FIFO write enable
out_data  output  DATA_W  output FIFO write data
busy  output  1  block in progress
block_done  output  1  one-cycle pulse per completed block
block_count  output  16  completed blocks, wraps 0xFFFF->0
err  output  2  sticky: [0] write attempted while out_full, [1] unexpected core result

Behaviour:
Reset (rst_n low, async):
- State is IDLE. All outputs are 0. rd_cnt, wr_cnt, block_count and err are 0.

States: IDLE, READ, DRAIN, DONE.

IDLE:
- Moves to READ when all of the following hold: enable=1, in_rd_count >= BLOCK_WORDS, and (OUT_DEPTH - out_wr_count) >= BLOCK_WORDS.
- Compute free space at CNT_W+1 bits, unsigned.
- On the transition, clear rd_cnt and wr_cnt and set busy=1.

READ:
- in_rd_en = 1 whenever state==READ, rd_cnt < BLOCK_WORDS and in_empty=0.
- rd_cnt increments on each in_rd_en.
- When the final read is issued (rd_cnt reaches BLOCK_WORDS), the next state is DRAIN.
- in_empty=1 mid-block holds in_rd_en low. This is not an error.

DRAIN:
- Waits until wr_cnt == BLOCK_WORDS, then moves to DONE.
- If READ completes with wr_cnt already at BLOCK_WORDS, the controller passes through DRAIN for one cycle.

DONE (one cycle):
- block_done=1 and block_count increments.
- busy drops on entry to IDLE.
- A new block may start on the cycle after DONE, so back-to-back blocks have a 2-cycle gap.

Input path:
- core_in_valid and core_in_data are registered from in_valid and in_data, in every state.
- Latency: in_rd_en at cycle t, in_valid at t+1, core_in_valid at t+2.

Output path:
- A core result is accepted when core_out_valid=1, state is READ or DRAIN, and wr_cnt < BLOCK_WORDS.
- On an accepted result, wr_cnt increments, and out_wr_en and out_data register it at t+1, provided out_full=0.
- If an accepted result arrives while out_full=1: the write is suppressed, err[0] is set, and wr_cnt still increments so the block terminates.
- core_out_valid in IDLE or DONE, or with wr_cnt already at BLOCK_WORDS: the word is dropped and err[1] is set.

enable:
- enable=0 mid-block does not abort the block; it only blocks the next start.

err:
- Bits clear only on reset.
- Setting a bit has no effect on sequencing.

Core:
- The core is assumed to produce exactly one result per input word, at any latency of at least 1 cycle.

Test Plan:
- in_rd_count=16, out_wr_count=0, enable=1, core is a 3-cycle delay -> exactly 16 in_rd_en pulses. block_done pulses once, block_count=1, 16 out_wr_en with data in order, err=0.
- in_rd_count=15 held -> stays IDLE, in_rd_en never asserted. Raise to 16 -> block starts next cycle.
- out_wr_count=113 (free space 15), in_rd_count=32 -> no start. out_wr_count=112 -> start.
- in_rd_count=48, enable held -> 3 blocks, block_count=3, exactly 2 idle cycles between each DONE and the next in_rd_en.
- out_full forced high during result 5 -> that write is suppressed, err=2'b01, block still completes. core_out_valid pulsed in IDLE -> err=2'b11.
- rst_n low during READ at rd_cnt=7 -> all outputs 0 immediately (async). After release with in_rd_count>=16, a fresh 16-read block starts. enable dropped mid-block -> block finishes, no restart.
